// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - frame accumulator of signed-sum 6x6 products with sticky overflow
module prod_accum #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [11:0]        in_data,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W:0]     cnt;
    logic               ovf;
    logic               load;
    logic               beat;
    logic [LEN_W:0]     len_ext;
    logic [ACC_W:0]     acc_ext;
    logic [ACC_W:0]     prod_ext;
    logic [ACC_W:0]     sum;
    logic               sum_ovf;

    assign len_ext  = (len == '0) ? CNT_MAX : {1'b0, len};
    assign acc_ext  = {acc[ACC_W-1], acc};
    assign prod_ext = {{(ACC_W - 11){1'b0}}, in_data};
    assign sum      = in_sub ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
    // One sign-extension bit is enough: the operand is far smaller than the accumulator range.
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        beat      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                beat     = in_valid;
                if (in_valid && (cnt == CNT_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                acc <= '0;
                ovf <= 1'b0;
                cnt <= len_ext;
            end else if (beat) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum_ovf;
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Result registers double as the accumulator, so they hold through IDLE until the next start.
    assign out_data = acc;
    assign out_ovf  = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - table-driven scoreboard bench for prod_accum
module tb_prod_accum;

    localparam int ACC_W = 16;
    localparam int LEN_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [11:0]       in_data = '0;
    logic              in_sub = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic              busy;

    prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   len;
        int           n;
        int           gap;
        logic [191:0] data;
        logic [15:0]  sub;
        logic [15:0]  exp_data;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        o;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int step(input int acc, input logic [11:0] d, input logic s, output logic ov);
        int r;
        r  = s ? acc - int'(d) : acc + int'(d);
        ov = 1'b0;
        if (r > 32767) begin
            r  = r - 65536;
            ov = 1'b1;
        end else if (r < -32768) begin
            r  = r + 65536;
            ov = 1'b1;
        end
        return r;
    endfunction

    function automatic vec_t mk(input int n, input int gap, input logic [15:0] ed, input logic eo);
        vec_t v;
        v.len      = n[3:0];
        v.n        = n;
        v.gap      = gap;
        v.data     = '0;
        v.sub      = '0;
        v.exp_data = ed;
        v.exp_ovf  = eo;
        return v;
    endfunction

    function automatic void put(input int k, input int i, input int d, input logic s);
        vecs[k].data[i*12 +: 12] = d[11:0];
        vecs[k].sub[i]           = s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got result %0h expected none", out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_data", {16'd0, out_data}, {16'd0, e.d});
                chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e.o});
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int   m;
        logic ov;
        exp_t e;
        m = 0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = v.len;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'($urandom);
        chk("accum_busy", {31'd0, busy}, 32'd1);
        chk("accum_in_ready", {31'd0, in_ready}, 32'd1);
        chk("accum_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_data  = v.data[i*12 +: 12];
            in_sub   = v.sub[i];
            @(posedge clk); #1;
            m = step(m, v.data[i*12 +: 12], v.sub[i], ov);
            in_valid = 1'b0;
            in_data  = 12'($urandom);
            in_sub   = 1'($urandom);
            if (i < v.n - 1) begin
                chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
                for (int g = 0; g < v.gap; g++) begin
                    chk("gap_hold", {16'd0, out_data}, {16'd0, m[15:0]});
                    @(posedge clk); #1;
                end
            end
        end
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        e.d = v.exp_data;
        e.o = v.exp_ovf;
        sb.push_back(e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_hold", {16'd0, out_data}, {16'd0, v.exp_data});
    endtask

    initial begin
        vec_t r;
        int   m;
        logic ov;
        logic o;

        vecs[0] = mk(3, 0, 16'h0FE6, 1'b0);
        put(0, 0, 3969, 1'b0); put(0, 1, 100, 1'b0); put(0, 2, 1, 1'b0);
        vecs[1] = mk(2, 3, 16'hFFF9, 1'b0);
        put(1, 0, 5, 1'b0); put(1, 1, 12, 1'b1);
        vecs[2] = mk(9, 0, 16'h8B89, 1'b1);
        for (int i = 0; i < 9; i++) put(2, i, 3969, 1'b0);
        vecs[3] = mk(1, 0, 16'h0001, 1'b0);
        put(3, 0, 1, 1'b0);
        vecs[4] = mk(16, 0, 16'h0010, 1'b0);
        for (int i = 0; i < 16; i++) put(4, i, 1, 1'b0);
        vecs[5] = mk(9, 1, 16'h7477, 1'b1);
        for (int i = 0; i < 9; i++) put(5, i, 3969, 1'b1);
        vecs[6] = mk(3, 0, 16'hFFFF, 1'b0);
        put(6, 0, 4095, 1'b0); put(6, 1, 4095, 1'b1); put(6, 2, 1, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Result held in DONE while start/in_valid hammer the block.
        @(posedge clk); #1;
        start = 1'b1; len = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 12'd7; in_sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_data = 12'd99; len = 4'd5;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {16'd0, out_data}, 32'd7);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        sb.push_back('{d: 16'd7, o: 1'b0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("handoff_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("handoff_idle", {31'd0, busy}, 32'd0);

        // Reset mid-frame aborts it; the first edge after release takes a new start.
        @(posedge clk); #1;
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 12'd3969; in_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_data", {16'd0, out_data}, 32'd7938);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {16'd0, out_data}, 32'd0);
        chk("arst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        run_frame(vecs[0]);

        for (int k = 0; k < 3; k++) begin
            r = mk($urandom_range(16, 1), $urandom_range(2, 0), 16'd0, 1'b0);
            m = 0;
            o = 1'b0;
            for (int i = 0; i < r.n; i++) begin
                r.data[i*12 +: 12] = 12'($urandom);
                r.sub[i]           = 1'($urandom);
                m = step(m, r.data[i*12 +: 12], r.sub[i], ov);
                o = o | ov;
            end
            r.exp_data = m[15:0];
            r.exp_ovf  = o;
            run_frame(r);
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
